ps2_drive_key_tracker: RTL

Converts the raw PS/2 byte stream into debounced held-key state for the two drive keys, and arbitrates them into the 2-bit `accel` command. It sits between `PS2_Controller` and the game datapath, replacing last-byte latching. It decodes make (`XX`), break (`F0 XX`), extended (`E0 XX` / `E0 F0 XX`) and Pause (`E1` + 7 bytes) sequences. A key therefore reads as held from its make code until its break code.

---
 rtl/ps2_pkg.sv | 57 +++++
 rtl/ps2_seq_timeout.sv | 46 ++++
 rtl/ps2_drive_key_tracker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 drive-key tracker.
//   - PS/2 set-2 prefix / control scan codes
//   - accel command encodings
//   - tracker FSM state type
//   - small decode / arbitration helpers
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_BATERR = 8'hFC;
    localparam logic [7:0] SC_OVR_00 = 8'h00;
    localparam logic [7:0] SC_OVR_FF = 8'hFF;

    localparam logic [1:0] ACCEL_GO    = 2'b10;
    localparam logic [1:0] ACCEL_BRAKE = 2'b01;
    localparam logic [1:0] ACCEL_COAST = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    // Keyboard responses and overrun markers that carry no key information.
    function automatic logic is_ignored_code(input logic [7:0] code);
        logic ign;
        case (code)
            SC_ACK, SC_RESEND, SC_BATERR, SC_OVR_00, SC_OVR_FF: ign = 1'b1;
            default:                                            ign = 1'b0;
        endcase
        return ign;
    endfunction

    // Both held -> most recently pressed key wins; otherwise the held key.
    function automatic logic [1:0] accel_arb(input logic go_held,
                                             input logic brk_held,
                                             input logic last_brake);
        logic [1:0] cmd;
        if (go_held && brk_held) begin
            cmd = last_brake ? ACCEL_BRAKE : ACCEL_GO;
        end else if (go_held) begin
            cmd = ACCEL_GO;
        end else if (brk_held) begin
            cmd = ACCEL_BRAKE;
        end else begin
            cmd = ACCEL_COAST;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_seq_timeout.sv
// ps2_seq_timeout: inter-byte watchdog for multi-byte PS/2 sequences.
//   clk_i     system clock
//   rst_n_i   asynchronous active-low reset
//   run_i     a sequence is in progress (count while high, hold at 0 when low)
//   load_i    byte strobe; reloads the count to 0 and suppresses expiry
//   expire_o  high in the cycle the count sits at LIMIT-1 with no strobe
module ps2_seq_timeout #(
    parameter int unsigned LIMIT = 32'd100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic load_i,
    output logic expire_o
);
    import ps2_pkg::*;

    localparam int unsigned CW = (LIMIT > 32'd1) ? $clog2(LIMIT) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expire_s;

    // Next count: a strobe wins over expiry; expiry restarts from zero.
    always_comb begin
        expire_s = run_i && !load_i && (cnt_q == LAST);
        if (!run_i || load_i || expire_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = expire_s;

endmodule

// File: rtl/ps2_drive_key_tracker.sv
// ps2_drive_key_tracker: decodes the PS/2 byte stream into held-key flags
// for the accelerate and brake keys and arbitrates them into `accel`.
//   CLOCK_50          system clock
//   resetn            asynchronous active-low reset
//   received_data     byte from PS2_Controller, valid with received_data_en
//   received_data_en  one-cycle byte strobe
//   accel             registered command: 10 go, 01 brake, 00 coast
//   accel_held        accelerate key held
//   brake_held        brake key held
//   key_event         one-cycle pulse when either held flag changes
//   seq_error         one-cycle pulse when a multi-byte sequence times out
module ps2_drive_key_tracker #(
    parameter logic [7:0]  KEY_ACCEL      = 8'h75,
    parameter logic [7:0]  KEY_BRAKE      = 8'h72,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [1:0] accel,
    output logic       accel_held,
    output logic       brake_held,
    output logic       key_event,
    output logic       seq_error
);
    import ps2_pkg::*;

    ps2_state_e state_q, state_d;
    logic [2:0] pause_cnt_q, pause_cnt_d;
    logic       accel_held_q, accel_held_d;
    logic       brake_held_q, brake_held_d;
    logic       last_brake_q, last_brake_d;   // 1: brake was pressed most recently
    logic [1:0] accel_q, accel_d;
    logic       key_event_q, key_event_d;
    logic       seq_error_q, seq_error_d;
    logic       do_make_s, do_break_s, do_bat_s;
    logic       expire_s;

    ps2_seq_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (CLOCK_50),
        .rst_n_i  (resetn),
        .run_i    (state_q != ST_IDLE),
        .load_i   (received_data_en),
        .expire_o (expire_s)
    );

    // Sequence decode, held-flag update and arbitration.
    always_comb begin
        state_d      = state_q;
        pause_cnt_d  = pause_cnt_q;
        accel_held_d = accel_held_q;
        brake_held_d = brake_held_q;
        last_brake_d = last_brake_q;
        seq_error_d  = 1'b0;
        do_make_s    = 1'b0;
        do_break_s   = 1'b0;
        do_bat_s     = 1'b0;

        if (received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (received_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (received_data == SC_PAUSE) begin
                        state_d     = ST_PAUSE;
                        pause_cnt_d = 3'd7;
                    end else if (received_data == SC_BAT) begin
                        do_bat_s = 1'b1;
                    end else if (is_ignored_code(received_data)) begin
                        state_d = ST_IDLE;
                    end else begin
                        do_make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (received_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (received_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        do_make_s = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if ((received_data == SC_BRK) || (received_data == SC_EXT)) begin
                        state_d = state_q;
                    end else begin
                        do_break_s = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    // Seven trailing Pause bytes are swallowed whatever their value.
                    if (pause_cnt_q <= 3'd1) begin
                        pause_cnt_d = 3'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    pause_cnt_d = 3'd0;
                end
            endcase
        end else if (expire_s) begin
            state_d     = ST_IDLE;
            pause_cnt_d = 3'd0;
            seq_error_d = 1'b1;
        end else begin
            state_d = state_q;
        end

        // Typematic repeats of an already-held key leave flags and priority alone.
        if (do_make_s && (received_data == KEY_ACCEL) && !accel_held_q) begin
            accel_held_d = 1'b1;
            last_brake_d = 1'b0;
        end else if (do_break_s && (received_data == KEY_ACCEL)) begin
            accel_held_d = 1'b0;
        end else if (do_bat_s) begin
            accel_held_d = 1'b0;
        end else begin
            accel_held_d = accel_held_d;
        end

        if (do_make_s && (received_data == KEY_BRAKE) && !brake_held_q) begin
            brake_held_d = 1'b1;
            last_brake_d = 1'b1;
        end else if (do_break_s && (received_data == KEY_BRAKE)) begin
            brake_held_d = 1'b0;
        end else if (do_bat_s) begin
            brake_held_d = 1'b0;
        end else begin
            brake_held_d = brake_held_d;
        end

        accel_d     = accel_arb(accel_held_d, brake_held_d, last_brake_d);
        key_event_d = (accel_held_d != accel_held_q) || (brake_held_d != brake_held_q);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pause_cnt_q  <= 3'd0;
            accel_held_q <= 1'b0;
            brake_held_q <= 1'b0;
            last_brake_q <= 1'b0;
            accel_q      <= ACCEL_COAST;
            key_event_q  <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pause_cnt_q  <= pause_cnt_d;
            accel_held_q <= accel_held_d;
            brake_held_q <= brake_held_d;
            last_brake_q <= last_brake_d;
            accel_q      <= accel_d;
            key_event_q  <= key_event_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign accel      = accel_q;
    assign accel_held = accel_held_q;
    assign brake_held = brake_held_q;
    assign key_event  = key_event_q;
    assign seq_error  = seq_error_q;

endmodule
